// File: rtl/beep_pkg.sv
// beep_pkg -- shared encodings and helpers for the beep sequencer.
//   mode_e  : pattern select latched at start (A/B, A only, B only, A/silence)
//   state_e : sequencer FSM states
//   tone_e  : tone chosen for the current segment
//   cnt_width()  : counter width for a given terminal value (at least 1 bit)
//   seg_tone()   : tone for a segment, given the mode and the segment's parity
package beep_pkg;

    typedef enum logic [1:0] {
        MODE_AB = 2'b00,
        MODE_A  = 2'b01,
        MODE_B  = 2'b10,
        MODE_AS = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        TONE_A   = 2'b00,
        TONE_B   = 2'b01,
        TONE_OFF = 2'b10
    } tone_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Even segments play A (B in MODE_B); odd segments depend on the mode.
    function automatic tone_e seg_tone(input mode_e mode, input logic odd);
        tone_e t;
        if (mode == MODE_B)      t = TONE_B;
        else if (!odd)           t = TONE_A;
        else if (mode == MODE_AB) t = TONE_B;
        else if (mode == MODE_A) t = TONE_A;
        else                     t = TONE_OFF;
        return t;
    endfunction

endpackage

// File: rtl/beep_seq_if.sv
// beep_seq_if -- control/status bundle of the beep sequencer.
//   start, abort, mode : requests from the controlling side (master)
//   beep, busy, over   : buzzer drive and status from the sequencer (slave)
interface beep_seq_if;
    import beep_pkg::*;

    logic  start;
    logic  abort;
    mode_e mode;
    logic  beep;
    logic  busy;
    logic  over;

    modport master (output start, output abort, output mode,
                    input  beep,  input  busy,  input  over);

    modport slave  (input  start, input  abort, input  mode,
                    output beep,  output busy,  output over);

endinterface

// File: rtl/beep_tone_div.sv
// beep_tone_div -- square-wave generator for one tone at a time.
//   clk  : clock
//   st   : asynchronous active-low reset
//   clr  : synchronous clear of the counter and wave (wins over en)
//   en   : advance the tone counter
//   div  : half-period in clk cycles of the active tone (>= 1)
//   wave : registered square wave, toggles when the counter reaches div-1
module beep_tone_div
    import beep_pkg::*;
#(
    parameter int DIV_W = cnt_width(2),
    parameter int CNT_W = cnt_width(1)
) (
    input  logic             clk,
    input  logic             st,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             wave
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;
    logic             at_term;

    assign at_term = (DIV_W'(cnt_q) == div - DIV_W'(1));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (clr) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (en) begin
            if (at_term) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/beep_seq.sv
// beep_seq -- buzzer sequencer: plays NUM_SEG segments of SEG_LEN cycles,
// each segment carrying tone A, tone B or silence depending on the mode
// latched at start.
//   clk : clock (all state changes on its rising edge)
//   st  : asynchronous active-low reset
//   bus : beep_seq_if.slave -- start/abort/mode in, beep/busy/over out
module beep_seq
    import beep_pkg::*;
#(
    parameter int NUM_SEG = 10,
    parameter int SEG_LEN = 500,
    parameter int DIV_A   = 1,
    parameter int DIV_B   = 2
) (
    input  logic       clk,
    input  logic       st,
    beep_seq_if.slave  bus
);

    localparam int SEG_W   = cnt_width(NUM_SEG - 1);
    localparam int CYC_W   = cnt_width(SEG_LEN - 1);
    localparam int DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
    localparam int DIV_W   = cnt_width(DIV_MAX);
    localparam int TONE_W  = cnt_width(DIV_MAX - 1);

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEG - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SEG_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_A_V  = DIV_W'(DIV_A);
    localparam logic [DIV_W-1:0] DIV_B_V  = DIV_W'(DIV_B);

    state_e           state_q, state_d;
    mode_e            mode_q,  mode_d;
    logic [SEG_W-1:0] seg_q,   seg_d;
    logic [CYC_W-1:0] cyc_q,   cyc_d;
    logic             busy_q,  busy_d;
    logic             over_q,  over_d;

    logic             seg_end;
    logic             seq_end;
    tone_e            tone;
    logic             tone_clr;
    logic [DIV_W-1:0] tone_div;
    logic             wave;

    assign seg_end = (cyc_q == CYC_LAST);
    assign seq_end = seg_end && (seg_q == SEG_LAST);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seg_d   = seg_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // abort outranks start; from IDLE it simply keeps IDLE.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_PLAY;
                    mode_d  = bus.mode;
                    seg_d   = '0;
                    cyc_d   = '0;
                end
            end
            S_PLAY: begin
                if (bus.abort || seq_end) begin
                    state_d = bus.abort ? S_IDLE : S_DONE;
                    seg_d   = '0;
                    cyc_d   = '0;
                end else if (seg_end) begin
                    seg_d   = seg_q + SEG_W'(1);
                    cyc_d   = '0;
                end else begin
                    cyc_d   = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                seg_d   = '0;
                cyc_d   = '0;
            end
        endcase
        busy_d = (state_d == S_PLAY);
        over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_AB;
            seg_q   <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seg_q   <= seg_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
        end
    end

    // The tone runs only while staying inside the same PLAY segment; the
    // start edge, every segment boundary, the last edge and abort all clear
    // it, so each segment begins in phase with beep=0.
    assign tone     = seg_tone(mode_q, seg_q[0]);
    assign tone_clr = !(state_q == S_PLAY && state_d == S_PLAY && !seg_end)
                      || (tone == TONE_OFF);
    assign tone_div = (tone == TONE_B) ? DIV_B_V : DIV_A_V;

    beep_tone_div #(
        .DIV_W (DIV_W),
        .CNT_W (TONE_W)
    ) u_tone (
        .clk  (clk),
        .st   (st),
        .clr  (tone_clr),
        .en   (!tone_clr),
        .div  (tone_div),
        .wave (wave)
    );

    assign bus.beep = wave;
    assign bus.busy = busy_q;
    assign bus.over = over_q;

endmodule

// File: tb/tb_beep_seq.sv
// tb_beep_seq -- randomized bench for beep_seq. Two instances: the default
// parameter set and a tiny one (NUM_SEG=1, SEG_LEN=2, DIV_B=3). A reference
// model tracks elapsed cycles since start and derives beep from segment
// number and offset with plain arithmetic.
module tb_beep_seq;
    import beep_pkg::*;

    localparam int P_N [2] = '{10, 1};
    localparam int P_L [2] = '{500, 2};
    localparam int P_DA[2] = '{1, 1};
    localparam int P_DB[2] = '{2, 3};

    logic clk = 1'b0;
    logic st;

    beep_seq_if bus0();
    beep_seq_if bus1();

    beep_seq #(.NUM_SEG(10), .SEG_LEN(500), .DIV_A(1), .DIV_B(2)) u_dut0 (
        .clk (clk),
        .st  (st),
        .bus (bus0)
    );

    beep_seq #(.NUM_SEG(1), .SEG_LEN(2), .DIV_A(1), .DIV_B(3)) u_dut1 (
        .clk (clk),
        .st  (st),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = playing (m_t cycles since the start edge), 2 = done.
    int m_phase[2];
    int m_t[2];
    int m_mode[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;
            m_t[i]     = 0;
            m_mode[i]  = 0;
        end
    endtask

    task automatic model_step(input int id, input logic s, input logic a, input logic [1:0] m);
        if (a) begin
            m_phase[id] = 0;
        end else if (m_phase[id] != 1 && s) begin
            m_phase[id] = 1;
            m_t[id]     = 0;
            m_mode[id]  = int'(m);
        end else if (m_phase[id] == 1) begin
            m_t[id]++;
            if (m_t[id] == P_N[id] * P_L[id]) m_phase[id] = 2;
        end
    endtask

    // Expected {beep, busy, over}.
    function automatic logic [2:0] model_out(input int id);
        int seg, j, d;
        logic quiet, b;
        if (m_phase[id] == 0) return 3'b000;
        if (m_phase[id] == 2) return 3'b001;
        seg   = m_t[id] / P_L[id];
        j     = m_t[id] % P_L[id];
        quiet = 1'b0;
        d     = P_DA[id];
        if (m_mode[id] == 2)           d = P_DB[id];
        else if (seg % 2 == 0)         d = P_DA[id];
        else if (m_mode[id] == 0)      d = P_DB[id];
        else if (m_mode[id] == 1)      d = P_DA[id];
        else                           quiet = 1'b1;
        b = quiet ? 1'b0 : ((j / d) % 2 == 1);
        return {b, 1'b1, 1'b0};
    endfunction

    task automatic compare_all();
        logic [2:0] e0, e1;
        e0 = model_out(0);
        e1 = model_out(1);
        check("d0_beep", 32'(bus0.beep), 32'(e0[2]));
        check("d0_busy", 32'(bus0.busy), 32'(e0[1]));
        check("d0_over", 32'(bus0.over), 32'(e0[0]));
        check("d1_beep", 32'(bus1.beep), 32'(e1[2]));
        check("d1_busy", 32'(bus1.busy), 32'(e1[1]));
        check("d1_over", 32'(bus1.over), 32'(e1[0]));
    endtask

    // One clock: dut0 gets the given inputs, dut1 gets random ones.
    task automatic tick(input logic s0, input logic a0, input logic [1:0] m0);
        logic s1, a1;
        logic [1:0] m1;
        s1 = ($urandom_range(0, 2) == 0);
        a1 = ($urandom_range(0, 15) == 0);
        m1 = 2'($urandom_range(0, 3));
        bus0.start = s0;
        bus0.abort = a0;
        bus0.mode  = mode_e'(m0);
        bus1.start = s1;
        bus1.abort = a1;
        bus1.mode  = mode_e'(m1);
        @(posedge clk);
        model_step(0, s0, a0, m0);
        model_step(1, s1, a1, m1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset_check();
        #2 st = 1'b0;
        #1;
        check("rst_beep0", 32'(bus0.beep), 32'd0);
        check("rst_busy0", 32'(bus0.busy), 32'd0);
        check("rst_over0", 32'(bus0.over), 32'd0);
        check("rst_beep1", 32'(bus1.beep), 32'd0);
        check("rst_busy1", 32'(bus1.busy), 32'd0);
        check("rst_over1", 32'(bus1.over), 32'd0);
        model_reset();
        #1 st = 1'b1;
    endtask

    initial begin
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.mode = MODE_AB;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.mode = MODE_AB;
        st = 1'b1;
        model_reset();
        @(negedge clk);
        async_reset_check();

        for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

        // Mode 00 full sequence; stray starts and mode changes during PLAY.
        tick(1'b1, 1'b0, MODE_AB);
        for (int i = 0; i < 4999; i++) tick(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 2'($urandom_range(0, 3)));

        // Restart from DONE in mode 11, run to DONE, then abort out of DONE.
        tick(1'b1, 1'b0, MODE_AS);
        for (int i = 0; i < 5004; i++) tick(1'b0, 1'b0, MODE_AB);
        tick(1'b0, 1'b1, MODE_AB);

        // Abort at cycle 1234, with start also high; then restart in mode 10.
        tick(1'b1, 1'b0, MODE_A);
        for (int i = 0; i < 1233; i++) tick(1'b0, 1'b0, MODE_A);
        tick(1'b1, 1'b1, MODE_B);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, MODE_B);
        tick(1'b1, 1'b0, MODE_B);
        for (int i = 0; i < 600; i++) tick(1'b0, 1'b0, MODE_B);

        // Asynchronous reset at cycle 700 of a fresh sequence.
        tick(1'b0, 1'b1, MODE_AB);
        tick(1'b1, 1'b0, MODE_AB);
        for (int i = 0; i < 700; i++) tick(1'b0, 1'b0, MODE_AB);
        async_reset_check();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, MODE_AB);
        tick(1'b1, 1'b0, MODE_AB);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, MODE_AB);

        // start held high through DONE: back-to-back sequences.
        tick(1'b0, 1'b1, MODE_AB);
        for (int i = 0; i < 10010; i++) tick(1'b1, 1'b0, MODE_A);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beep_seq.md
BEEP_SEQ -- requirements
Module: beep_seq

Interface
REQ-001 Parameter NUM_SEG, default 10: number of tone segments per sequence, minimum 1.
REQ-002 Parameter SEG_LEN, default 500: clk cycles per segment, minimum 2.
REQ-003 Parameter DIV_A, default 1: tone A half-period in clk cycles (500 Hz at 1 kHz clk), minimum 1.
REQ-004 Parameter DIV_B, default 2: tone B half-period in clk cycles (250 Hz at 1 kHz clk), minimum 1.
REQ-005 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 Port st, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: start request, sampled in IDLE and DONE only.
REQ-008 Port abort, input, 1: synchronous stop of the sequence.
REQ-009 Port mode, input, 2: pattern select, latched at start; 00 = A/B alternate, 01 = A only, 10 = B only, 11 = A/silence alternate.
REQ-010 Port beep, output, 1: registered square-wave buzzer drive.
REQ-011 Port busy, output, 1: high while in PLAY.
REQ-012 Port over, output, 1: sticky completion flag, high while in DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, PLAY and DONE.
REQ-014 IDLE->PLAY on start=1 && abort=0; mode is latched, and the segment counter, cycle counter, tone counter and beep are all cleared.
REQ-015 In PLAY, the cycle counter SHALL count 0..SEG_LEN-1; at SEG_LEN-1 it wraps to 0 and the segment counter increments.
REQ-016 At cycle SEG_LEN-1 of segment NUM_SEG-1, the FSM SHALL go PLAY->DONE, over is set and beep is forced to 0 on that same edge.
REQ-017 Segment tone selection:
- Even segments play tone A, except mode 10, which plays tone B on every segment.
- Odd segments play tone B in mode 00, tone A in mode 01, tone B in mode 10, and silence in mode 11.
REQ-018 Tone generation: the tone counter counts 0..DIV-1 for the active tone; at DIV-1, beep toggles and the counter returns to 0.
REQ-019 At every segment boundary, the tone counter and beep SHALL be cleared, so each segment starts in phase with beep=0.
REQ-020 During a silent segment, beep SHALL be held at 0 and the tone counter at 0.
REQ-021 When start is sampled at edge k, the first beep rise SHALL occur at edge k+DIV of segment 0's tone.
REQ-022 abort=1 in PLAY or DONE SHALL force IDLE at the next edge, with beep=0, busy=0 and over=0; abort has priority over start and over segment-end.
REQ-023 start during PLAY SHALL be ignored; the latched mode does not change mid-sequence.
REQ-024 DONE->PLAY on start=1 && abort=0 (restart): over clears on the same edge.
REQ-025 DONE with no start SHALL hold over=1 and beep=0 indefinitely.
REQ-026 Counter widths: $clog2 of (max value + 1), minimum 1 bit; no counter may exceed its terminal value.
REQ-027 Total duration of one sequence: NUM_SEG*SEG_LEN cycles from the start edge to the over-rise edge.

Reset
REQ-028 st=0 SHALL asynchronously force IDLE, with every counter at 0, latched mode 00, beep=0, busy=0 and over=0.
REQ-029 st asserted mid-PLAY SHALL abandon the sequence; after release, the block waits in IDLE for start.
REQ-030 Deassertion of st is synchronous to clk and requires no extra idle cycles.

Structure
REQ-031 Shared package beep_pkg SHALL hold the mode encodings (MODE_AB, MODE_A, MODE_B, MODE_AS) and the state encodings (S_IDLE, S_PLAY, S_DONE).
REQ-032 Sub-module beep_tone_div SHALL hold the tone counter and beep toggle.
- Inputs: clk, st, clr, en, div.
- Output: wave.
- beep_seq owns the FSM, the segment/cycle counters and the tone selection.
REQ-033 The implementation SHALL NOT use any derived or gated clocks; all logic runs on clk.

Verification
REQ-034 Defaults, mode 00, start pulse at cycle 0:
- Segment 0: beep toggles every cycle (period 2).
- Segment 1: beep toggles every 2 cycles (period 4).
- over rises at cycle 5000, with busy=1 throughout cycles 0..4999.
REQ-035 Mode 11: odd segments hold beep=0 for all 500 cycles; even segments show the period-2 wave.
REQ-036 abort at cycle 1234 of PLAY: next edge gives IDLE, beep=0, busy=0, over=0; a later start restarts from segment 0.
REQ-037 st pulled low at cycle 700: all outputs go 0 immediately, without waiting for clk; after release, beep stays 0 until start.
REQ-038 start held high through DONE: the sequence restarts and over is high for exactly one cycle between sequences.
REQ-039 Parameters NUM_SEG=1, SEG_LEN=2, DIV_B=3, mode 10: over rises 2 cycles after start, and beep never rises (the segment ends before DIV reaches 3).
